// File: rtl/loba_dot_acc.sv
// Frame-based dot-product accumulator for the LOBA multiplier product stream.
// Saturating sum/count per frame, result handed off on a valid/ready port.
module loba_dot_acc #(
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      in_p,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state, state_n;
  logic [ACC_W-1:0] acc, acc_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             ovf, ovf_n;
  logic [ACC_W:0]   sum_w;
  logic             accept;

  assign in_ready = (state == ACCUM) | out_ready;
  assign accept   = in_valid & in_ready;

  // acc/cnt/ovf are already zero whenever we sit in HOLD, so the same
  // update path also starts a fresh frame on a back-to-back accept.
  always_comb begin
    sum_w = {1'b0, acc} + {{(ACC_W + 1 - 32){1'b0}}, in_p};
    acc_n = sum_w[ACC_W] ? '1 : sum_w[ACC_W-1:0];
    ovf_n = ovf | sum_w[ACC_W];
    cnt_n = (&cnt) ? cnt : cnt + {{(CNT_W - 1){1'b0}}, 1'b1};
  end

  always_comb begin
    state_n = state;
    case (state)
      ACCUM: if (accept && in_last) state_n = HOLD;
      HOLD:  if (out_ready) state_n = (accept && in_last) ? HOLD : ACCUM;
      default: state_n = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      out_valid <= (state_n == HOLD);
      if (accept) begin
        if (in_last) begin
          out_sum   <= acc_n;
          out_count <= cnt_n;
          out_ovf   <= ovf_n;
          acc       <= '0;
          cnt       <= '0;
          ovf       <= 1'b0;
        end else begin
          acc <= acc_n;
          cnt <= cnt_n;
          ovf <= ovf_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_loba_dot_acc.sv
// Directed bench for loba_dot_acc (ACC_W=33, CNT_W=2) with a result scoreboard.
module tb_loba_dot_acc;

  localparam int ACC_W = 33;
  localparam int CNT_W = 2;
  localparam longint unsigned MAXV = (64'd1 << ACC_W) - 64'd1;
  localparam int unsigned CMAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [63:0] s;
    logic [31:0] c;
    logic        o;
  } res_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      in_p;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;
  logic             out_valid;
  logic             out_ready;

  int checks = 0;
  int errors = 0;

  res_t             sb[$];
  res_t             cur;
  longint unsigned  m_acc;
  int unsigned      m_cnt;
  logic             m_ovf;
  logic             m_hold;

  loba_dot_acc #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_p      (in_p),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_acc  = 0;
    m_cnt  = 0;
    m_ovf  = 1'b0;
    m_hold = 1'b0;
    sb.delete();
  endtask

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic step(input logic v, input logic [31:0] p, input logic l, input logic ordy);
    logic exp_rdy, acc_ok, load;
    res_t r;
    in_valid  = v;
    in_p      = p;
    in_last   = l;
    out_ready = ordy;
    #1;
    exp_rdy = !m_hold || ordy;
    chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
    acc_ok = v && exp_rdy;
    load   = 1'b0;
    if (acc_ok) begin
      if (m_acc + p > MAXV) begin
        m_acc = MAXV;
        m_ovf = 1'b1;
      end else begin
        m_acc = m_acc + p;
      end
      if (m_cnt < CMAX) m_cnt++;
      if (l) begin
        r.s = m_acc;
        r.c = m_cnt;
        r.o = m_ovf;
        sb.push_back(r);
        m_acc  = 0;
        m_cnt  = 0;
        m_ovf  = 1'b0;
        load   = 1'b1;
        m_hold = 1'b1;
      end else begin
        m_hold = 1'b0;
      end
    end else if (m_hold && ordy) begin
      m_hold = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("out_valid", {63'd0, out_valid}, {63'd0, m_hold});
    if (load) cur = sb.pop_front();
    if (m_hold) begin
      chk("out_sum",   {31'd0, out_sum},   cur.s);
      chk("out_count", {62'd0, out_count}, {32'd0, cur.c});
      chk("out_ovf",   {63'd0, out_ovf},   {63'd0, cur.o});
    end
    in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_out_sum"},   {31'd0, out_sum},   64'd0);
    chk({tag, "_out_count"}, {62'd0, out_count}, 64'd0);
    chk({tag, "_out_ovf"},   {63'd0, out_ovf},   64'd0);
    chk({tag, "_in_ready"},  {63'd0, in_ready},  64'd1);
  endtask

  // Asserts rst between edges so the clear must be asynchronous.
  task automatic pulse_reset(input string tag);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    #1;
    chk({tag, "_rel_in_ready"},  {63'd0, in_ready},  64'd1);
    chk({tag, "_rel_out_valid"}, {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_p      = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    model_clear();
    #1;
    check_reset_outputs("por");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic frame 3+5+7
    step(1'b1, 32'd3, 1'b0, 1'b1);
    step(1'b1, 32'd5, 1'b0, 1'b1);
    step(1'b1, 32'd7, 1'b1, 1'b1);
    // Stall four cycles, one with a term offered that must be refused
    step(1'b0, 32'd0, 1'b0, 1'b0);
    step(1'b1, 32'd99, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    // Drain and load a 1-term frame in the same edge
    step(1'b1, 32'd10, 1'b1, 1'b1);
    step(1'b0, 32'd0, 1'b0, 1'b1);

    // Sum saturation at 33 bits, then back-to-back 1-term frame
    step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
    step(1'b1, 32'd1, 1'b1, 1'b1);
    step(1'b0, 32'd0, 1'b0, 1'b1);

    // Count saturation at 2 bits
    for (int unsigned i = 0; i < 5; i++)
      step(1'b1, 32'd1, (i == 4), 1'b1);
    step(1'b0, 32'd0, 1'b0, 1'b1);

    // Valid gaps with junk on the bus during the gap
    step(1'b1, 32'h0001_0000, 1'b0, 1'b1);
    step(1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1);
    step(1'b1, 32'h0002_0000, 1'b1, 1'b1);
    step(1'b0, 32'd0, 1'b0, 1'b1);

    // Reset while holding a result
    step(1'b1, 32'd9, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    pulse_reset("rst_hold");
    step(1'b1, 32'd4, 1'b1, 1'b1);
    step(1'b0, 32'd0, 1'b0, 1'b1);

    // Reset mid-frame after two terms
    step(1'b1, 32'd2, 1'b0, 1'b1);
    step(1'b1, 32'd3, 1'b0, 1'b1);
    pulse_reset("rst_mid");
    step(1'b1, 32'd4, 1'b1, 1'b1);
    step(1'b0, 32'd0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
